// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter: two-master Wishbone arbiter in front of one shared SRAM slave, with a wait timeout
// Ports: clk/nrst clock and async active-low reset; m0_*/m1_* Wishbone master sides
// (cyc, stb, we, adr, dat, sel in; ack, err, dat out); s_* shared slave side;
// grant_o one-hot owner (bit0 = m0), busy_o high while a grant is held.
module wb_sram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic busy_q, busy_d;
  logic req0, req1, g0, g1, cyc_x, ack_x, tmo;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign g0 = state_q == GRANT0;
  assign g1 = state_q == GRANT1;
  assign cyc_x = g0 ? m0_cyc_i : g1 & m1_cyc_i;
  // a master that has dropped cyc gets no ack even if the slave answers late
  assign ack_x = cyc_x & s_ack_i;
  // ack in the last allowed cycle still wins over the timeout
  assign tmo = cyc_x & ~s_ack_i & (cnt_q == 8'(TIMEOUT - 1));
  assign s_cyc_o = cyc_x & ~tmo;
  assign s_stb_o = (g0 ? m0_stb_i : g1 & m1_stb_i) & ~tmo;
  assign s_we_o = g0 ? m0_we_i : g1 & m1_we_i;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : 32'd0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : 32'd0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'd0;
  assign m0_ack_o = g0 & ack_x;
  assign m1_ack_o = g1 & ack_x;
  assign m0_err_o = g0 & tmo;
  assign m1_err_o = g1 & tmo;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign busy_o = busy_q;
  // last_q is updated at grant time, so it always names the most recent owner
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 8'd1;
    last_d = last_q;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
      if (req0 & (~req1 | last_q)) begin
        state_d = GRANT0;
        last_d = 1'b0;
      end else if (req1) begin
        state_d = GRANT1;
        last_d = 1'b1;
      end
    end else if (ack_x | ~cyc_x | tmo) begin
      state_d = IDLE;
      cnt_d = 8'd0;
    end
    grant_d = {state_d == GRANT1, state_d == GRANT0};
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      last_q <= 1'b1;
      grant_q <= 2'b00;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      grant_q <= grant_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_wb_sram_arbiter.sv
// tb_wb_sram_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_wb_sram_arbiter;
  localparam int TO = 4;
  logic clk = 0, nrst = 0;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0] m0_sel, m1_sel;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o, busy_o;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0] s_sel_o;
  logic [1:0] grant_o;
  int checks = 0, errors = 0;
  int own, waited, last;
  wb_sram_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(grant_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r0, r1, ack;
    logic [1:0] grant;
    logic a0, a1, stb;
  } vec_t;
  vec_t tbl[9];
  function automatic logic [141:0] dut_out();
    return {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o,
            s_dat_o, s_sel_o, grant_o, busy_o, m0_dat_o, m1_dat_o};
  endfunction
  function automatic logic [141:0] model_out();
    logic mc, ms, mw, a, e;
    logic [31:0] ad, dd;
    logic [3:0] sl;
    mc = own == 1 ? m0_cyc : own == 2 ? m1_cyc : 1'b0;
    ms = own == 1 ? m0_stb : own == 2 ? m1_stb : 1'b0;
    mw = own == 1 ? m0_we : own == 2 ? m1_we : 1'b0;
    ad = own == 1 ? m0_adr : own == 2 ? m1_adr : 32'd0;
    dd = own == 1 ? m0_dat : own == 2 ? m1_dat : 32'd0;
    sl = own == 1 ? m0_sel : own == 2 ? m1_sel : 4'd0;
    a = mc && s_ack;
    e = mc && !s_ack && waited == TO - 1;
    return {own == 1 && a, own == 1 && e, own == 2 && a, own == 2 && e, mc && !e, ms && !e,
            mw, ad, dd, sl, own == 2, own == 1, own != 0, s_dat, s_dat};
  endfunction
  task automatic model_reset();
    own = 0;
    waited = 0;
    last = 1;
  endtask
  task automatic model_tick();
    logic mc;
    if (own == 0) begin
      if (m0_cyc && m0_stb && m1_cyc && m1_stb) own = last == 0 ? 2 : 1;
      else if (m0_cyc && m0_stb) own = 1;
      else if (m1_cyc && m1_stb) own = 2;
      if (own != 0) last = own - 1;
      waited = 0;
    end else begin
      mc = own == 1 ? m0_cyc : m1_cyc;
      if ((mc && s_ack) || !mc || waited == TO - 1) own = 0;
      else waited++;
    end
  endtask
  task automatic chk(input string n, input logic [141:0] got, input logic [141:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, got, exp);
    end
  endtask
  task automatic clr_in();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    {m0_adr, m0_dat, m1_adr, m1_dat, s_dat} = '0;
    {m0_sel, m1_sel} = '0;
  endtask
  task automatic settle();
    @(negedge clk);
    chk("model", dut_out(), model_out());
  endtask
  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask
  initial begin
    clr_in();
    model_reset();
    #12;
    chk("reset outputs", dut_out(), 142'd0);
    @(posedge clk);
    #1 nrst = 1;
    tbl[0] = '{1, 1, 0, 2'b00, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 2'b01, 0, 0, 1};
    tbl[2] = '{1, 1, 1, 2'b01, 1, 0, 1};
    tbl[3] = '{1, 1, 0, 2'b00, 0, 0, 0};
    tbl[4] = '{1, 1, 0, 2'b10, 0, 0, 1};
    tbl[5] = '{1, 1, 1, 2'b10, 0, 1, 1};
    tbl[6] = '{1, 1, 0, 2'b00, 0, 0, 0};
    tbl[7] = '{1, 1, 0, 2'b01, 0, 0, 1};
    tbl[8] = '{1, 1, 1, 2'b01, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      {m0_cyc, m0_stb} = {2{tbl[i].r0}};
      {m1_cyc, m1_stb} = {2{tbl[i].r1}};
      s_ack = tbl[i].ack;
      settle();
      chk($sformatf("tbl%0d grant", i), grant_o, tbl[i].grant);
      chk($sformatf("tbl%0d acks", i), {m0_ack_o, m1_ack_o}, {tbl[i].a0, tbl[i].a1});
      chk($sformatf("tbl%0d stb", i), s_stb_o, tbl[i].stb);
      advance();
    end
    clr_in();
    settle();
    advance();
    {m1_cyc, m1_stb, m1_we} = 3'b111;
    m1_adr = 32'h0000_0040;
    m1_dat = 32'hDEAD_BEEF;
    m1_sel = 4'hF;
    settle();
    chk("m1 write idle s_cyc", s_cyc_o, 0);
    advance();
    settle();
    chk("m1 write bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o},
        {3'b111, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF});
    chk("m1 write grant", grant_o, 2'b10);
    advance();
    s_ack = 1;
    settle();
    chk("m1 write ack", {m0_ack_o, m1_ack_o}, 2'b01);
    advance();
    clr_in();
    settle();
    advance();
    {m0_cyc, m0_stb} = 2'b11;
    settle();
    advance();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("timeout err c%0d", k), m0_err_o, k == 3);
      chk($sformatf("timeout cyc/stb c%0d", k), {s_cyc_o, s_stb_o}, k == 3 ? 2'b00 : 2'b11);
      advance();
    end
    clr_in();
    settle();
    chk("timeout then idle", {grant_o, busy_o, m0_err_o}, 4'b0000);
    advance();
    {m0_cyc, m0_stb} = 2'b11;
    settle();
    advance();
    {m1_cyc, m1_stb} = 2'b11;
    settle();
    advance();
    settle();
    advance();
    {m0_cyc, m0_stb} = 2'b00;
    settle();
    chk("abandon no ack/err", {m0_ack_o, m0_err_o, s_cyc_o}, 3'b000);
    advance();
    settle();
    chk("abandon turnaround", grant_o, 2'b00);
    advance();
    s_ack = 1;
    settle();
    chk("abandon m1 granted", grant_o, 2'b10);
    chk("abandon m1 ack", {m0_ack_o, m0_err_o, m1_ack_o}, 3'b001);
    advance();
    clr_in();
    settle();
    advance();
    {m1_cyc, m1_stb} = 2'b11;
    settle();
    advance();
    settle();
    chk("pre-reset grant", grant_o, 2'b10);
    nrst = 0;
    #1;
    chk("async reset outputs", dut_out(), 142'd0);
    model_reset();
    {m0_cyc, m0_stb} = 2'b11;
    @(posedge clk);
    #1 nrst = 1;
    settle();
    advance();
    s_ack = 1;
    settle();
    chk("post-reset tie to m0", grant_o, 2'b01);
    advance();
    clr_in();
    settle();
    advance();
    s_ack = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("idle ack ignored c%0d", k), {m0_ack_o, m1_ack_o}, 2'b00);
      advance();
    end
    for (int i = 0; i < 400; i++) begin
      m0_cyc = $urandom_range(0, 3) != 0;
      m0_stb = m0_cyc && $urandom_range(0, 4) != 0;
      m1_cyc = $urandom_range(0, 3) != 0;
      m1_stb = m1_cyc && $urandom_range(0, 4) != 0;
      m0_we = 1'($urandom);
      m1_we = 1'($urandom);
      m0_adr = $urandom;
      m0_dat = $urandom;
      m1_adr = $urandom;
      m1_dat = $urandom;
      m0_sel = 4'($urandom);
      m1_sel = 4'($urandom);
      s_ack = $urandom_range(0, 2) == 0;
      s_dat = $urandom;
      settle();
      advance();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_sram_arbiter.md
WB_SRAM_ARBITER -- requirements
Module: wb_sram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of granted cycles without a slave ACK before the transfer is aborted (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 nrst  input  1  asynchronous active-low reset.
REQ-004 mN_cyc_i, mN_stb_i, mN_we_i (N=0,1)  input  1 each  Wishbone master N cycle, strobe and write-enable.
REQ-005 mN_adr_i, mN_dat_i (N=0,1)  input  32 each  master N address and write data.
REQ-006 mN_sel_i (N=0,1)  input  4  master N byte selects.
REQ-007 mN_ack_o, mN_err_o (N=0,1)  output  1 each  ACK and timeout error returned to master N.
REQ-008 mN_dat_o (N=0,1)  output  32  read data to master N.
REQ-009 s_cyc_o, s_stb_o, s_we_o  output  1 each  to the shared SRAM Wishbone slave.
REQ-010 s_adr_o, s_dat_o  output  32 each; s_sel_o  output  4; all to the slave.
REQ-011 s_ack_i  input  1; s_dat_i  input  32; both from the slave.
REQ-012 grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.
REQ-013 busy_o  output  1  high while a grant is held.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT0, GRANT1; masters request with cyc&stb.
REQ-015 In IDLE, if exactly one master requests, the next state SHALL be that master's GRANT state.
REQ-016 In IDLE with both masters requesting, the master not served last SHALL be granted; a last_grant register SHALL record the most recently granted master.
REQ-017 Grant latency SHALL be one cycle: a request sampled in IDLE at edge N drives the slave bus from the cycle after edge N.
REQ-018 In GRANTx, s_cyc/stb/we/adr/dat/sel SHALL combinationally mirror master x; in IDLE they SHALL all be 0.
REQ-019 s_ack_i SHALL be routed combinationally to the granted master's ack only; the other master's ack and err SHALL be 0.
REQ-020 mN_dat_o SHALL equal s_dat_i for both masters at all times.
REQ-021 When s_ack_i=1 in GRANTx, the next state SHALL be IDLE and last_grant SHALL be set to x; every transfer is followed by one idle turnaround cycle.
REQ-022 If the granted master deasserts cyc before ACK, the transfer SHALL be abandoned: next state IDLE, no ack or err, last_grant set to x.
REQ-023 An 8-bit wait counter SHALL clear on entry to a GRANT state and increment each GRANT cycle without ACK.
REQ-024 The cycle the counter equals TIMEOUT-1 without ACK, the granted master's err SHALL pulse for one cycle, s_stb_o/s_cyc_o SHALL be forced 0 that cycle, and the next state SHALL be IDLE.
REQ-025 ACK and timeout in the same cycle: ACK SHALL win; no err is issued.
REQ-026 s_ack_i arriving in IDLE SHALL be ignored and not forwarded.
REQ-027 grant_o and busy_o SHALL be registered state decodes, with no combinational path from inputs.

Reset
REQ-028 While nrst=0: state IDLE, counter 0, last_grant=m1 (so m0 wins the first tie), grant_o=00, busy_o=0, all s_* outputs 0, all acks and errs 0.
REQ-029 Reset asserted mid-transfer SHALL drop s_cyc_o/s_stb_o immediately (asynchronously) with no ack forwarded.

Verification
REQ-030 Both masters request from reset, slave ACKs 1 cycle after stb -> m0 served first, then m1, then m0; grant_o sequence 01,00,10,00,01.
REQ-031 Only m1 requests: write adr=0x0000_0040, dat=0xDEAD_BEEF, sel=0xF -> the same values appear on s_* the cycle after the request; m1_ack_o pulses on s_ack_i.
REQ-032 Slave never ACKs, TIMEOUT=4 -> m0_err_o high exactly 4 cycles after grant, s_stb_o low that cycle, IDLE next.
REQ-033 m0 drops cyc 2 cycles into grant while m1 is waiting -> m1 granted 1 cycle later with no m0 ack/err.
REQ-034 nrst pulled low mid-GRANT1 -> all outputs 0 within the same cycle; first request after release is m0 on a tie.
REQ-035 s_ack_i pulsed while IDLE -> m0_ack_o and m1_ack_o stay 0.
